// File: rtl/led_pattern_gen.sv
// led_pattern_gen: turns the divider's slow square wave into a fast-domain
// tick and drives an OFF / ON / BLINK / BREATHE pattern onto the LED pin.
module led_pattern_gen #(
    parameter int pPwmBits    = 8,
    parameter int pStep       = 1,
    parameter int pSyncStages = 2
) (
    input  logic       iwClk,
    input  logic       iwRst,
    input  logic       iwSlowClk,
    input  logic [1:0] iwMode,
    input  logic       iwModeValid,
    output logic       orTick,
    output logic       orLed
);

    if (pStep < 1 || pStep > (2 ** pPwmBits) - 1 || pSyncStages < 2) begin : g_bad_param
        $error("led_pattern_gen: illegal pStep or pSyncStages");
    end

    localparam logic [1:0] cOff     = 2'd0;
    localparam logic [1:0] cOn      = 2'd1;
    localparam logic [1:0] cBlink   = 2'd2;
    localparam logic [1:0] cBreathe = 2'd3;

    localparam logic [pPwmBits:0] cStep = (pPwmBits + 1)'(pStep);
    localparam logic [pPwmBits:0] cMax  = {1'b0, {pPwmBits{1'b1}}};

    logic [pSyncStages-1:0] r_sync;
    logic                   r_hist;
    logic [1:0]             r_mode;
    logic [pPwmBits-1:0]    r_duty;
    logic [pPwmBits-1:0]    r_cnt;
    logic                   r_blink;
    logic                   r_dirDown;

    logic                   w_slowSync;
    logic [1:0]             w_mode;
    logic [pPwmBits-1:0]    w_duty;
    logic                   w_blink;
    logic                   w_dirDown;
    logic [pPwmBits:0]      w_sum;
    logic                   w_led;

    assign w_slowSync = r_sync[pSyncStages-1];

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            r_sync    <= '0;
            r_hist    <= 1'b0;
            orTick    <= 1'b0;
            orLed     <= 1'b0;
            r_mode    <= cOff;
            r_duty    <= '0;
            r_cnt     <= '0;
            r_blink   <= 1'b0;
            r_dirDown <= 1'b0;
        end else begin
            r_sync    <= {r_sync[pSyncStages-2:0], iwSlowClk};
            r_hist    <= w_slowSync;
            orTick    <= w_slowSync & ~r_hist;
            orLed     <= w_led;
            r_mode    <= w_mode;
            r_duty    <= w_duty;
            r_cnt     <= r_cnt + pPwmBits'(1);
            r_blink   <= w_blink;
            r_dirDown <= w_dirDown;
        end
    end

    // A real mode change clears pattern state and masks a coincident tick.
    always_comb begin
        w_mode    = r_mode;
        w_duty    = r_duty;
        w_blink   = r_blink;
        w_dirDown = r_dirDown;
        w_sum     = {1'b0, r_duty} + cStep;
        if (iwModeValid && (iwMode != r_mode)) begin
            w_mode    = iwMode;
            w_duty    = '0;
            w_blink   = 1'b0;
            w_dirDown = 1'b0;
        end else if (orTick) begin
            case (r_mode)
                cBlink: begin
                    w_blink = ~r_blink;
                end
                cBreathe: begin
                    if (!r_dirDown) begin
                        if (w_sum >= cMax) begin
                            w_duty    = cMax[pPwmBits-1:0];
                            w_dirDown = 1'b1;
                        end else begin
                            w_duty = w_sum[pPwmBits-1:0];
                        end
                    end else if ({1'b0, r_duty} <= cStep) begin
                        w_duty    = '0;
                        w_dirDown = 1'b0;
                    end else begin
                        w_duty = r_duty - cStep[pPwmBits-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_led = 1'b0;
        unique case (r_mode)
            cOff:     w_led = 1'b0;
            cOn:      w_led = 1'b1;
            cBlink:   w_led = r_blink;
            cBreathe: w_led = (r_cnt < r_duty);
        endcase
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen with a 4-bit
// PWM, step 5 and a 2-flop synchroniser.
module tb_led_pattern_gen;

    localparam int N    = 4;
    localparam int STEP = 5;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       slow = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       mv   = 1'b0;
    logic       tick;
    logic       led;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .pPwmBits(N),
        .pStep(STEP),
        .pSyncStages(2)
    ) dut (
        .iwClk(clk),
        .iwRst(rst),
        .iwSlowClk(slow),
        .iwMode(mode),
        .iwModeValid(mv),
        .orTick(tick),
        .orLed(led)
    );

    int checks = 0;
    int errors = 0;
    int nidx   = 0;
    int phase  = 0;
    bit slow_en = 1'b0;
    bit seen_tick;
    int exp_tick[$];
    int exp_val[$];

    // One cycle: sample at the falling edge, score ticks, then drive slow.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            nidx++;
            seen_tick = tick;
            while (exp_tick.size() > 0 && exp_tick[0] < nidx) begin
                checks++;
                errors++;
                $display("FAIL tick_missing got none required tick at cycle %0d", exp_tick[0]);
                void'(exp_tick.pop_front());
            end
            if (tick) begin
                checks++;
                if (exp_tick.size() == 0 || exp_tick[0] != nidx) begin
                    errors++;
                    $display("FAIL tick_timing got tick at cycle %0d required %0d",
                             nidx, (exp_tick.size() > 0) ? exp_tick[0] : -1);
                end else begin
                    void'(exp_tick.pop_front());
                end
            end
            if (slow_en) begin
                phase++;
                if (phase == 10) begin
                    phase = 0;
                    slow  = ~slow;
                    if (slow) exp_tick.push_back(nidx + 3);
                end
            end
        end
    endtask

    task automatic drive_mode(input logic [1:0] m);
        mode = m;
        mv   = 1'b1;
        run(1);
        mv   = 1'b0;
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            run(1);
            k++;
        end while (!seen_tick && k < 40);
        if (!seen_tick) begin
            checks++;
            errors++;
            $display("FAIL wait_tick got no tick within 40 cycles required one");
        end
    endtask

    task automatic measure(output int hi);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            run(1);
            hi += int'(led);
        end
    endtask

    task automatic test_reset();
        int hi;
        rst  = 1'b1;
        slow = 1'b1;
        run(3);
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick got %b required 0", tick);
        end
        checks++;
        if (led !== 1'b0) begin
            errors++;
            $display("FAIL reset_led got %b required 0", led);
        end
        rst = 1'b0;
        exp_tick.push_back(nidx + 3);
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            run(1);
            hi += int'(led);
        end
        slow = 1'b0;
        run(4);
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL reset_off_led got %0d high cycles required 0", hi);
        end
    endtask

    task automatic test_tick();
        int hi;
        slow_en = 1'b1;
        phase   = 0;
        hi      = 0;
        for (int i = 0; i < 60; i++) begin
            run(1);
            hi += int'(led);
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL off_led got %0d high cycles required 0", hi);
        end
    endtask

    task automatic test_on_blink();
        bit b;
        wait_tick();
        run(2);
        drive_mode(2'd1);
        checks++;
        if (led !== 1'b0) begin
            errors++;
            $display("FAIL on_latency got %b required 0", led);
        end
        run(1);
        checks++;
        if (led !== 1'b1) begin
            errors++;
            $display("FAIL on_led got %b required 1", led);
        end
        wait_tick();
        run(2);
        drive_mode(2'd2);
        run(1);
        checks++;
        if (led !== 1'b0) begin
            errors++;
            $display("FAIL blink_start got %b required 0", led);
        end
        b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            exp_val.push_back(int'(b));
            b = ~b;
            exp_val.push_back(int'(b));
            run(1);
            checks++;
            if (int'(led) != exp_val[0]) begin
                errors++;
                $display("FAIL blink_hold got %b required %0d", led, exp_val[0]);
            end
            void'(exp_val.pop_front());
            run(1);
            checks++;
            if (int'(led) != exp_val[0]) begin
                errors++;
                $display("FAIL blink_toggle got %b required %0d", led, exp_val[0]);
            end
            void'(exp_val.pop_front());
        end
    endtask

    task automatic test_breathe();
        int hi;
        int tbl[7] = '{5, 10, 15, 10, 5, 0, 5};
        wait_tick();
        run(2);
        drive_mode(2'd3);
        exp_val.push_back(0);
        measure(hi);
        checks++;
        if (hi != exp_val[0]) begin
            errors++;
            $display("FAIL breathe_duty0 got %0d required %0d", hi, exp_val[0]);
        end
        void'(exp_val.pop_front());
        for (int i = 0; i < 7; i++) begin
            wait_tick();
            exp_val.push_back(tbl[i]);
            run(1);
            measure(hi);
            checks++;
            if (hi != exp_val[0]) begin
                errors++;
                $display("FAIL breathe_step%0d got %0d high of 16 required %0d",
                         i, hi, exp_val[0]);
            end
            void'(exp_val.pop_front());
        end
    endtask

    task automatic test_mode_vs_tick();
        int hi;
        run(1);
        drive_mode(2'd2);
        wait_tick();
        drive_mode(2'd3);
        exp_val.push_back(0);
        measure(hi);
        checks++;
        if (hi != exp_val[0]) begin
            errors++;
            $display("FAIL collide_duty got %0d required %0d", hi, exp_val[0]);
        end
        void'(exp_val.pop_front());
        wait_tick();
        exp_val.push_back(STEP);
        run(1);
        measure(hi);
        checks++;
        if (hi != exp_val[0]) begin
            errors++;
            $display("FAIL collide_next got %0d required %0d", hi, exp_val[0]);
        end
        void'(exp_val.pop_front());
        wait_tick();
        exp_val.push_back(2 * STEP);
        run(1);
        drive_mode(2'd3);
        measure(hi);
        checks++;
        if (hi != exp_val[0]) begin
            errors++;
            $display("FAIL restrobe_duty got %0d required %0d", hi, exp_val[0]);
        end
        void'(exp_val.pop_front());
    endtask

    task automatic test_reset_mid();
        int hi;
        int k;
        wait_tick();
        wait_tick();
        run(1);
        k = 0;
        do begin
            run(1);
            k++;
        end while (led !== 1'b1 && k < 16);
        checks++;
        if (led !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_led got %b required 1", led);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (led !== 1'b0) begin
            errors++;
            $display("FAIL async_led got %b required 0", led);
        end
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL async_tick got %b required 0", tick);
        end
        exp_tick.delete();
        slow_en = 1'b0;
        slow    = 1'b0;
        run(3);
        rst = 1'b0;
        measure(hi);
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL post_reset_led got %0d required 0", hi);
        end
        slow_en = 1'b1;
        phase   = 0;
        drive_mode(2'd3);
        wait_tick();
        exp_val.push_back(STEP);
        run(1);
        measure(hi);
        checks++;
        if (hi != exp_val[0]) begin
            errors++;
            $display("FAIL post_reset_duty got %0d required %0d", hi, exp_val[0]);
        end
        void'(exp_val.pop_front());
    endtask

    initial begin
        test_reset();
        test_tick();
        test_on_blink();
        test_breathe();
        test_mode_vs_tick();
        test_reset_mid();
        slow_en = 1'b0;
        run(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Downstream consumer of the clock divider's slow square-wave output. It synchronises and edge-detects the divided clock into a single-cycle tick in the fast clock domain. The tick drives a selectable LED pattern: off, solid, blink, or PWM "breathing". The block sits between the divider and the board LED pin.

Parameters:
pPwmBits, 8, width of the PWM counter and duty register (N); PWM period is 2^N iwClk cycles
pStep, 1, duty increment/decrement applied per tick in BREATHE mode; legal range 1..2^N-1
pSyncStages, 2, number of flops synchronising iwSlowClk; minimum 2

Ports:
iwClk  input  1  fast system clock; all logic is on its rising edge
iwRst  input  1  asynchronous, active-high reset
iwSlowClk  input  1  divided square wave from the clock divider; treated as asynchronous
iwMode  input  2  requested pattern: 0=OFF, 1=ON, 2=BLINK, 3=BREATHE
iwModeValid  input  1  one-cycle strobe qualifying iwMode
orTick  output  1  one-cycle pulse per rising edge of iwSlowClk
orLed  output  1  registered LED drive

Behaviour:
- Reset (async assert, sync release): sync chain=0, edge-history flop=0, orTick=0, orLed=0, mode=OFF, duty=0, PWM counter=0, blink state=0, direction=UP.
- Tick generation: iwSlowClk passes through pSyncStages flops, then a history flop. orTick=1 for exactly one cycle when the last sync stage is 1 and the history flop is 0. Latency is pSyncStages+1 cycles from the iwSlowClk rise to the orTick assertion. Falling edges produce no tick. If iwSlowClk is already high when reset releases, the first tick is generated after pSyncStages+1 cycles.
- PWM counter: N-bit, free-running, increments every cycle in all modes, wraps 2^N-1 -> 0.
- Mode register: loaded on the cycle after iwModeValid=1.
  - If the new mode differs from the current mode: duty=0, blink state=0, direction=UP.
  - If it equals the current mode: no state change.
- Pattern state update on a tick, per mode:
  - OFF, ON: no pattern state.
  - BLINK: blink state toggles.
  - BREATHE, direction UP: compute duty+pStep in N+1 bits. If the result is >= 2^N-1, duty=2^N-1 and direction=DOWN; else duty+=pStep.
  - BREATHE, direction DOWN: if duty <= pStep, duty=0 and direction=UP; else duty-=pStep.
  - Duty never wraps.
- Same-cycle tick and accepted mode change: the mode change wins and the tick is ignored for pattern state. orTick still pulses.
- orLed (registered, 1-cycle latency from its inputs):
  - OFF: 0.
  - ON: 1.
  - BLINK: blink state.
  - BREATHE: (PWM counter < duty).
- BREATHE duty extremes: duty=0 gives orLed constantly 0. Duty=2^N-1 gives orLed=1 for 2^N-1 of every 2^N cycles.
- Reset mid-operation: all state returns to reset values immediately. orLed drops to 0 asynchronously.
- Illegal parameters (pStep=0, pSyncStages<2) are rejected at elaboration.

Test Plan:
1. Reset then square wave on iwSlowClk (period 20 cycles, pSyncStages=2) -> orTick pulses 1 cycle wide, 3 cycles after each rise, none on falls; orLed=0 (mode OFF).
2. iwMode=1 with strobe -> orLed=1 two cycles after the strobe. Then iwMode=2 -> orLed toggles once per tick, starting 0, first high one cycle after the first tick.
3. BREATHE, pPwmBits=4, pStep=5 -> duty sequence over successive ticks is 0,5,10,15(dir DOWN),10,5,0(dir UP),5. At duty=5, orLed is high for exactly 5 of every 16 cycles.
4. Strobe BREATHE in the same cycle as a tick while in BLINK -> duty stays 0 after that tick; the next tick gives duty=pStep. Re-strobing BREATHE mid-ramp leaves duty unchanged.
5. Assert iwRst while in BREATHE with duty=10 -> orLed=0 and orTick=0 immediately. After release, mode=OFF and duty=0; the first tick appears 3 cycles after the next iwSlowClk rise.
